spi_word_bridge: RTL and testbench



---
 rtl/spi_pkg.sv | 13 +
 rtl/sync_edge.sv | 32 +++
 rtl/spi_word_bridge.sv | 157 +++++++++++++++
 tb/tb_spi_word_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word bridge.
package spi_pkg;

  localparam int SPI_WORD_W = 16;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_t;

  typedef logic [SPI_WORD_W-1:0] spi_word_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall detect
// taken from the two most recent synchronised samples.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= {STAGES{RST_VAL}};
      prev_reg  <= RST_VAL;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], din};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign sync = chain_reg[STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_word_bridge.sv
// SPI mode-0 slave front end: oversamples the SPI pins in the clk domain,
// turns MOSI into a valid-pulsed word stream and serialises tx words on MISO.
module spi_word_bridge
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_err
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sck_rise, sck_fall, sck_sync;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .din (spi_sck),
    .sync(sck_sync),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  // cs_n chain resets low: after reset a frame already in progress produces
  // no falling edge, so it is ignored until cs_n has actually been seen high.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .din (spi_cs_n),
    .sync(cs_sync),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .din (spi_mosi),
    .sync(mosi_sync),
    .rise(mosi_rise),
    .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = sck_sync ^ cs_rise ^ mosi_rise ^ mosi_fall;

  spi_state_t        state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-2:0] rx_shift_reg;
  logic [DATA_W-2:0] tx_shift_reg;   // bits still to send after the one on MISO
  logic [DATA_W-1:0] hold_reg;
  logic              tx_ready_reg;   // doubles as the holding-register empty flag
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              frame_err_reg;
  logic              spi_miso_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
      hold_reg      <= '0;
      tx_ready_reg  <= 1'b1;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      spi_miso_reg  <= 1'b0;
    end else begin
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;

      // A transfer never coincides with a reload of a full register, so the
      // reload below only ever empties a register the bus cannot write.
      if (tx_valid && tx_ready_reg) begin
        hold_reg     <= tx_data;
        tx_ready_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          bit_cnt_reg  <= '0;
          spi_miso_reg <= 1'b0;
          if (cs_fall) begin
            state_reg <= ACTIVE;
            if (!tx_ready_reg) begin
              tx_shift_reg <= hold_reg[DATA_W-2:0];
              spi_miso_reg <= hold_reg[DATA_W-1];
              tx_ready_reg <= 1'b1;
            end else begin
              tx_shift_reg <= '0;
              spi_miso_reg <= 1'b0;
            end
          end
        end

        ACTIVE: begin
          if (cs_sync) begin
            // cs_n rising wins over any sck edge seen in the same cycle
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            spi_miso_reg  <= 1'b0;
            frame_err_reg <= (bit_cnt_reg != '0);
          end else if (sck_rise) begin
            rx_shift_reg <= {rx_shift_reg[DATA_W-3:0], mosi_sync};
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_reg  <= '0;
              rx_data_reg  <= {rx_shift_reg, mosi_sync};
              rx_valid_reg <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else if (sck_fall) begin
            if (bit_cnt_reg != '0) begin
              tx_shift_reg <= {tx_shift_reg[DATA_W-3:0], 1'b0};
              spi_miso_reg <= tx_shift_reg[DATA_W-2];
            end else if (!tx_ready_reg) begin
              tx_shift_reg <= hold_reg[DATA_W-2:0];
              spi_miso_reg <= hold_reg[DATA_W-1];
              tx_ready_reg <= 1'b1;
            end else begin
              tx_shift_reg <= '0;
              spi_miso_reg <= 1'b0;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spi_miso  = spi_miso_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign tx_ready  = tx_ready_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_word_bridge.sv
// Self-checking bench for spi_word_bridge: table of single frames, hand-written
// corner sequences, and randomised multi-word frames against a queue model.
module tb_spi_word_bridge;
  import spi_pkg::*;

  localparam int W    = SPI_WORD_W;
  localparam int SYNC = 2;
  localparam int HALF = 4;   // sck half period in clk cycles (sck = clk/8)

  logic      clk = 1'b0;
  logic      rst;
  logic      spi_sck, spi_cs_n, spi_mosi, spi_miso;
  spi_word_t rx_data, tx_data;
  logic      rx_valid, tx_valid, tx_ready, frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_rise_cyc = 0;
  int ferr_cnt = 0;
  spi_word_t rx_q[$];
  int        lat_q[$];

  spi_word_bridge #(.DATA_W(W), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Collect every rx_valid cycle and every frame_err cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      lat_q.push_back(cyc - last_rise_cyc);
    end
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer_tx(input spi_word_t w, input logic exp_ready);
    check("tx_ready_before_offer", 32'(tx_ready), 32'(exp_ready));
    tx_data  = w;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check("tx_ready_after_offer", 32'(tx_ready), 32'(1'b0));
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    tick(HALF);
    spi_sck = 1'b1;
    last_rise_cyc = cyc;
    m = spi_miso;
    tick(HALF);
    spi_sck = 1'b0;
  endtask

  // Clock nbits of w MSB first; optionally offer a tx word before bit 4.
  task automatic spi_word(input spi_word_t w, input int nbits, input logic offer,
                          input spi_word_t offer_w, input logic exp_ready,
                          output spi_word_t miso_w);
    logic m;
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      if (offer && i == 4) offer_tx(offer_w, exp_ready);
      spi_bit(w[W-1-i], m);
      miso_w[W-1-i] = m;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  typedef struct {
    int        nbits;
    spi_word_t mosi_w;
    logic      offer;
    spi_word_t offer_w;
    int        exp_rx;
    spi_word_t exp_rx_data;
    spi_word_t exp_miso;
    int        exp_ferr;
  } vec_t;

  vec_t      vecs[6];
  spi_word_t miso_w;
  int        ferr0;

  initial begin
    vecs[0] = '{16, 16'h1001, 1'b0, 16'h0000, 1, 16'h1001, 16'h0000, 0};
    vecs[1] = '{16, 16'h3C3C, 1'b1, 16'h5A5A, 1, 16'h3C3C, 16'h5A5A, 0};
    vecs[2] = '{ 7, 16'hFFFF, 1'b0, 16'h0000, 0, 16'h3C3C, 16'h0000, 1};
    vecs[3] = '{16, 16'h2002, 1'b0, 16'h0000, 1, 16'h2002, 16'h0000, 0};
    vecs[4] = '{16, 16'hFFFF, 1'b1, 16'h8001, 1, 16'hFFFF, 16'h8001, 0};
    vecs[5] = '{16, 16'h0000, 1'b0, 16'h0000, 1, 16'h0000, 16'h0000, 0};

    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(6);
    check("reset_rx_data",   32'(rx_data),   32'h0);
    check("reset_rx_valid",  32'(rx_valid),  32'h0);
    check("reset_spi_miso",  32'(spi_miso),  32'h0);
    check("reset_tx_ready",  32'(tx_ready),  32'h1);
    check("reset_frame_err", 32'(frame_err), 32'h0);

    // Table of single frames
    for (int k = 0; k < 6; k++) begin
      rx_q.delete();
      ferr0 = ferr_cnt;
      if (vecs[k].offer) offer_tx(vecs[k].offer_w, 1'b1);
      cs_low();
      check("tx_ready_after_cs_fall", 32'(tx_ready), 32'h1);
      spi_word(vecs[k].mosi_w, vecs[k].nbits, 1'b0, '0, 1'b1, miso_w);
      cs_high();
      check("vec_rx_count",  32'(rx_q.size()),     32'(vecs[k].exp_rx));
      check("vec_rx_data",   32'(rx_data),         32'(vecs[k].exp_rx_data));
      check("vec_miso",      32'(miso_w),          32'(vecs[k].exp_miso));
      check("vec_frame_err", 32'(ferr_cnt - ferr0), 32'(vecs[k].exp_ferr));
      check("vec_tx_ready",  32'(tx_ready),        32'h1);
      $display("vec %0d: bits=%0d mosi=%04h rx=%04h miso=%04h", k, vecs[k].nbits,
               vecs[k].mosi_w, rx_data, miso_w);
    end

    // Two back-to-back words in one frame
    rx_q.delete();
    ferr0 = ferr_cnt;
    cs_low();
    spi_word(16'h1001, 16, 1'b0, '0, 1'b1, miso_w);
    spi_word(16'hABCD, 16, 1'b0, '0, 1'b1, miso_w);
    cs_high();
    check("b2b_count", 32'(rx_q.size()), 32'd2);
    check("b2b_word0", rx_q.size() > 0 ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'h1001);
    check("b2b_word1", rx_q.size() > 1 ? 32'(rx_q[1]) : 32'hFFFF_FFFF, 32'hABCD);
    check("b2b_frame_err", 32'(ferr_cnt - ferr0), 32'd0);
    $display("b2b frame: %0d words received", rx_q.size());

    // Reset in the middle of a word, with a tx word pending
    rx_q.delete();
    cs_low();
    spi_word(16'hFFFF, 9, 1'b1, 16'h1234, 1'b1, miso_w);
    rst = 1'b1;
    tick(2);
    check("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check("midrst_tx_ready", 32'(tx_ready), 32'h1);
    check("midrst_spi_miso", 32'(spi_miso), 32'h0);
    rst = 1'b0;
    tick(4);
    ferr0 = ferr_cnt;
    spi_word(16'hFFFF, 7, 1'b0, '0, 1'b1, miso_w);
    check("midrst_tail_miso",  32'(miso_w),      32'h0);
    check("midrst_tail_count", 32'(rx_q.size()), 32'd0);
    cs_high();
    check("midrst_frame_err", 32'(ferr_cnt - ferr0), 32'd0);
    cs_low();
    spi_word(16'h1002, 16, 1'b0, '0, 1'b1, miso_w);
    cs_high();
    check("postrst_count",   32'(rx_q.size()), 32'd1);
    check("postrst_rx_data", 32'(rx_data),     32'h1002);
    $display("reset recovery: rx=%04h", rx_data);

    // Random frames against a one-deep holding-register model
    begin
      spi_word_t hq[$];
      spi_word_t sent[$];
      spi_word_t exp_miso, w, ow;
      logic      offer_mid;
      int        total = 0;
      int        nw;
      while (total < 100) begin
        nw = $urandom_range(1, 4);
        if (nw > 100 - total) nw = 100 - total;
        rx_q.delete(); lat_q.delete(); sent.delete();
        ferr0 = ferr_cnt;
        check("rand_tx_ready_idle", 32'(tx_ready), 32'(hq.size() == 0));
        if ($urandom_range(0, 1) == 1) begin
          ow = spi_word_t'($urandom);
          offer_tx(ow, 1'b1);
          hq.push_back(ow);
        end
        cs_low();
        exp_miso = (hq.size() > 0) ? hq.pop_front() : '0;
        for (int j = 0; j < nw; j++) begin
          w = spi_word_t'($urandom);
          ow = spi_word_t'($urandom);
          offer_mid = (hq.size() == 0) && ($urandom_range(0, 2) == 0);
          spi_word(w, 16, offer_mid, ow, 1'b1, miso_w);
          if (offer_mid) hq.push_back(ow);
          sent.push_back(w);
          check("rand_miso", 32'(miso_w), 32'(exp_miso));
          exp_miso = (hq.size() > 0) ? hq.pop_front() : '0;
        end
        cs_high();
        check("rand_rx_count", 32'(rx_q.size()), 32'(nw));
        for (int j = 0; j < nw; j++) begin
          check("rand_rx_data", rx_q.size() > j ? 32'(rx_q[j]) : 32'hFFFF_FFFF, 32'(sent[j]));
          check("rand_latency", lat_q.size() > j ? 32'(lat_q[j]) : 32'hFFFF_FFFF, 32'(SYNC + 1));
        end
        check("rand_frame_err", 32'(ferr_cnt - ferr0), 32'd0);
        $display("random frame: %0d words, first=%04h, total=%0d", nw, sent[0], total + nw);
        total += nw;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
